// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: parametrised GPIO pin core.
//
// Sits between the pad ring and a register-file wrapper. Provides, per pin:
//   - input synchroniser (SyncStages deep, 0 = sample the pad directly)
//   - glitch filter with a shared runtime threshold
//   - masked writes to the output and output-enable registers
//   - push-pull or open-drain pad drive
//   - rise / fall / high / low interrupt detection with sticky, clearable state
// plus one registered, aggregated interrupt.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   gpio_i                pad inputs (asynchronous)
//   gpio_o, gpio_en_o     pad output data / output enables
//   filter_en_i           per-pin filter enable
//   filter_thresh_i       shared filter threshold
//   out_we_i/_mask_i/_data_i  masked write to the output register
//   oe_we_i/_mask_i/_data_i   masked write to the output-enable register
//   od_en_i               per-pin open-drain mode
//   intr_{rise,fall,high,low}_en_i  per-pin event enables
//   intr_enable_i         per-pin contribution to intr_o
//   intr_clear_i          write-1-to-clear pulses for interrupt state
//   intr_test_i           pulses that set interrupt state
//   data_in_o             filtered input value
//   out_q_o, oe_q_o       register readback
//   intr_state_o          sticky interrupt state
//   intr_o                aggregated interrupt, registered
module gpio_pin_ctrl #(
   parameter int unsigned NumPins    = 32,
   parameter int unsigned CntWidth   = 4,
   parameter int unsigned SyncStages = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPins-1:0]  gpio_i,
   output logic [NumPins-1:0]  gpio_o,
   output logic [NumPins-1:0]  gpio_en_o,
   input  logic [NumPins-1:0]  filter_en_i,
   input  logic [CntWidth-1:0] filter_thresh_i,
   input  logic                out_we_i,
   input  logic [NumPins-1:0]  out_mask_i,
   input  logic [NumPins-1:0]  out_data_i,
   input  logic                oe_we_i,
   input  logic [NumPins-1:0]  oe_mask_i,
   input  logic [NumPins-1:0]  oe_data_i,
   input  logic [NumPins-1:0]  od_en_i,
   input  logic [NumPins-1:0]  intr_rise_en_i,
   input  logic [NumPins-1:0]  intr_fall_en_i,
   input  logic [NumPins-1:0]  intr_high_en_i,
   input  logic [NumPins-1:0]  intr_low_en_i,
   input  logic [NumPins-1:0]  intr_enable_i,
   input  logic [NumPins-1:0]  intr_clear_i,
   input  logic [NumPins-1:0]  intr_test_i,
   output logic [NumPins-1:0]  data_in_o,
   output logic [NumPins-1:0]  out_q_o,
   output logic [NumPins-1:0]  oe_q_o,
   output logic [NumPins-1:0]  intr_state_o,
   output logic                intr_o
);

   // ---------------------------------------------------------------------------
   // Input synchroniser
   // ---------------------------------------------------------------------------
   logic [NumPins-1:0] sync_s;

   if (SyncStages == 0) begin : g_no_sync
      assign sync_s = gpio_i;
   end else begin : g_sync
      logic [NumPins-1:0] sync_q [SyncStages];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int unsigned k = 0; k < SyncStages; k++) begin
               sync_q[k] <= '0;
            end
         end else begin
            sync_q[0] <= gpio_i;
            for (int unsigned k = 1; k < SyncStages; k++) begin
               sync_q[k] <= sync_q[k-1];
            end
         end
      end

      assign sync_s = sync_q[SyncStages-1];
   end

   // ---------------------------------------------------------------------------
   // Glitch filter: the output follows the candidate only once the candidate has
   // been seen on threshold+1 consecutive further samples.
   // ---------------------------------------------------------------------------
   logic [NumPins-1:0] data_in;

   for (genvar i = 0; i < NumPins; i++) begin : g_filt
      logic                cand_q;
      logic                filt_q;
      logic [CntWidth-1:0] cnt_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            cand_q <= 1'b0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
         end else if (!filter_en_i[i]) begin
            filt_q <= sync_s[i];
            cand_q <= sync_s[i];
            cnt_q  <= '0;
         end else if (sync_s[i] != cand_q) begin
            cand_q <= sync_s[i];
            cnt_q  <= '0;
         end else if (cnt_q < filter_thresh_i) begin
            // Ordered compare so a threshold lowered below cnt counts as reached.
            cnt_q <= cnt_q + 1'b1;
         end else begin
            filt_q <= cand_q;
         end
      end

      assign data_in[i] = filt_q;
   end

   assign data_in_o = data_in;

   // ---------------------------------------------------------------------------
   // Output / output-enable registers and interrupt state
   // ---------------------------------------------------------------------------
   logic [NumPins-1:0] out_q, out_d;
   logic [NumPins-1:0] oe_q, oe_d;
   logic [NumPins-1:0] prev_q;
   logic [NumPins-1:0] intr_state_q, intr_state_d;
   logic               intr_q, intr_d;
   logic [NumPins-1:0] ev;

   always_comb begin
      out_d = out_q;
      if (out_we_i) begin
         out_d = (out_mask_i & out_data_i) | (~out_mask_i & out_q);
      end

      oe_d = oe_q;
      if (oe_we_i) begin
         oe_d = (oe_mask_i & oe_data_i) | (~oe_mask_i & oe_q);
      end

      ev = (~prev_q &  data_in & intr_rise_en_i)
         | ( prev_q & ~data_in & intr_fall_en_i)
         | ( data_in & intr_high_en_i)
         | (~data_in & intr_low_en_i);

      // Set terms are ORed after the clear, so set wins over a same-cycle clear.
      intr_state_d = (intr_state_q & ~intr_clear_i) | ev | intr_test_i;
      intr_d       = |(intr_state_q & intr_enable_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q        <= '0;
         oe_q         <= '0;
         prev_q       <= '0;
         intr_state_q <= '0;
         intr_q       <= 1'b0;
      end else begin
         out_q        <= out_d;
         oe_q         <= oe_d;
         prev_q       <= data_in;
         intr_state_q <= intr_state_d;
         intr_q       <= intr_d;
      end
   end

   // Open-drain pins never drive high: they drive 0 or release the pad.
   assign gpio_o    = out_q & ~od_en_i;
   assign gpio_en_o = oe_q & ~(od_en_i & out_q);

   assign out_q_o      = out_q;
   assign oe_q_o       = oe_q;
   assign intr_state_o = intr_state_q;
   assign intr_o       = intr_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Self-checking bench for gpio_pin_ctrl: directed scenarios with constant
// expectations, then randomised segments compared against a behavioural model.
module tb_gpio_pin_ctrl;

   localparam int unsigned NP = 32;
   localparam int unsigned CW = 4;
   localparam int unsigned SS = 2;
   localparam int unsigned HD = (1 << CW) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [NP-1:0] gpio_in, gpio_out, gpio_en;
   logic [NP-1:0] fen;
   logic [CW-1:0] thresh;
   logic          out_we, oe_we;
   logic [NP-1:0] out_mask, out_data, oe_mask, oe_data, od;
   logic [NP-1:0] rise_en, fall_en, high_en, low_en, ien, clr, tst;
   logic [NP-1:0] data_in, out_q, oe_q, state;
   logic          irq;

   always #5 clk = ~clk;

   gpio_pin_ctrl #(.NumPins(NP), .CntWidth(CW), .SyncStages(SS)) dut (
      .clk_i(clk), .rst_i(rst), .gpio_i(gpio_in), .gpio_o(gpio_out), .gpio_en_o(gpio_en),
      .filter_en_i(fen), .filter_thresh_i(thresh),
      .out_we_i(out_we), .out_mask_i(out_mask), .out_data_i(out_data),
      .oe_we_i(oe_we), .oe_mask_i(oe_mask), .oe_data_i(oe_data), .od_en_i(od),
      .intr_rise_en_i(rise_en), .intr_fall_en_i(fall_en), .intr_high_en_i(high_en),
      .intr_low_en_i(low_en), .intr_enable_i(ien), .intr_clear_i(clr), .intr_test_i(tst),
      .data_in_o(data_in), .out_q_o(out_q), .oe_q_o(oe_q), .intr_state_o(state),
      .intr_o(irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: the pad value is delayed SS samples, and the filtered
   // value becomes v once the last thresh+2 synchronised samples all equal v.
   // ---------------------------------------------------------------------------
   logic [NP-1:0] m_sync [SS+1];
   logic [NP-1:0] m_hist [HD];
   logic [NP-1:0] m_f, m_prev, m_st, m_out, m_oe;
   logic          m_irq;

   task automatic model_reset();
      for (int k = 0; k <= SS; k++) m_sync[k] = '0;
      for (int j = 0; j < HD; j++) m_hist[j] = '0;
      m_f = '0; m_prev = '0; m_st = '0; m_out = '0; m_oe = '0; m_irq = 1'b0;
   endtask

   task automatic model_step();
      logic [NP-1:0] s_now, eq, f_new, ev;
      int            k;
      if (rst) begin
         model_reset();
         return;
      end
      k     = (SS == 0) ? 0 : SS - 1;
      s_now = (SS == 0) ? gpio_in : m_sync[k];
      for (int j = SS; j > 0; j--) m_sync[j] = m_sync[j-1];
      m_sync[0] = gpio_in;
      for (int j = HD - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = s_now;
      eq = '1;
      for (int j = 1; j <= int'(thresh) + 1; j++) eq &= ~(m_hist[j] ^ m_hist[0]);
      f_new = (~fen & s_now) | (fen & eq & s_now) | (fen & ~eq & m_f);
      ev = (~m_prev & m_f & rise_en) | (m_prev & ~m_f & fall_en)
         | (m_f & high_en) | (~m_f & low_en);
      m_irq  = |(m_st & ien);
      m_st   = (m_st & ~clr) | ev | tst;
      m_prev = m_f;
      m_f    = f_new;
      if (out_we) m_out = (out_mask & out_data) | (~out_mask & m_out);
      if (oe_we)  m_oe  = (oe_mask & oe_data) | (~oe_mask & m_oe);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic compare_all();
      check_eq("rnd data_in", data_in, m_f);
      check_eq("rnd gpio_o", gpio_out, m_out & ~od);
      check_eq("rnd gpio_en_o", gpio_en, m_oe & ~(od & m_out));
      check_eq("rnd out_q", out_q, m_out);
      check_eq("rnd oe_q", oe_q, m_oe);
      check_eq("rnd intr_state", state, m_st);
      check_eq("rnd intr_o", {31'b0, irq}, {31'b0, m_irq});
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, " data_in"}, data_in, '0);
      check_eq({tag, " gpio_o"}, gpio_out, '0);
      check_eq({tag, " gpio_en_o"}, gpio_en, '0);
      check_eq({tag, " out_q"}, out_q, '0);
      check_eq({tag, " oe_q"}, oe_q, '0);
      check_eq({tag, " intr_state"}, state, '0);
      check_eq({tag, " intr_o"}, {31'b0, irq}, '0);
   endtask

   task automatic clear_inputs();
      gpio_in = '0; fen = '0; thresh = '0; out_we = 0; oe_we = 0;
      out_mask = '0; out_data = '0; oe_mask = '0; oe_data = '0; od = '0;
      rise_en = '0; fall_en = '0; high_en = '0; low_en = '0; ien = '0; clr = '0; tst = '0;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      tick(); tick();
      check_zero("reset");
      rst = 1'b0;

      // Masked writes
      out_we = 1; out_mask = 32'h0000FFFF; out_data = 32'hFFFFFFFF;
      tick();
      out_we = 0;
      check_eq("mw out_q half", out_q, 32'h0000FFFF);
      check_eq("mw gpio_o half", gpio_out, 32'h0000FFFF);
      out_we = 1; out_mask = 32'hFFFF0000; out_data = 32'h0;
      oe_we = 1; oe_mask = 32'hFFFFFFFF; oe_data = 32'hA5A5A5A5;
      tick();
      out_we = 0; oe_we = 0;
      check_eq("mw out_q unchanged", out_q, 32'h0000FFFF);
      check_eq("mw oe_q full", oe_q, 32'hA5A5A5A5);

      // Open-drain on pin 3
      oe_we = 1; oe_mask = 32'h8; oe_data = 32'h8;
      out_we = 1; out_mask = 32'h8; out_data = 32'h0;
      tick();
      oe_we = 0; out_we = 0;
      od = 32'h8;
      #1;
      check_eq("od low en", {31'b0, gpio_en[3]}, 32'h1);
      check_eq("od low data", {31'b0, gpio_out[3]}, 32'h0);
      out_we = 1; out_mask = 32'h8; out_data = 32'h8;
      tick();
      out_we = 0;
      check_eq("od high en", {31'b0, gpio_en[3]}, 32'h0);
      check_eq("od high data", {31'b0, gpio_out[3]}, 32'h0);
      check_eq("pp gpio_en", gpio_en & 32'hFFFFFFF7, 32'hA5A5A5A5);
      od = '0;

      // Filter on pin 0, threshold 3
      fen = 32'h1; thresh = 4'd3;
      gpio_in[0] = 1'b1;
      repeat (3) tick();
      gpio_in[0] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         check_eq("filt short pulse", {31'b0, data_in[0]}, 32'h0);
      end
      gpio_in[0] = 1'b1;
      repeat (6) tick();
      check_eq("filt edge 6", {31'b0, data_in[0]}, 32'h0);
      tick();
      check_eq("filt edge 7", {31'b0, data_in[0]}, 32'h1);
      gpio_in[0] = 1'b0; fen = '0;
      repeat (5) tick();
      check_eq("nofilt low", {31'b0, data_in[0]}, 32'h0);
      gpio_in[0] = 1'b1;
      tick(); tick();
      check_eq("nofilt edge 2", {31'b0, data_in[0]}, 32'h0);
      tick();
      check_eq("nofilt edge 3", {31'b0, data_in[0]}, 32'h1);

      // Rise interrupt on pin 5 and clear
      rise_en = 32'h20; ien = 32'h20;
      gpio_in[5] = 1'b1;
      repeat (3) tick();
      check_eq("rise data_in", {31'b0, data_in[5]}, 32'h1);
      check_eq("rise state pre", {31'b0, state[5]}, 32'h0);
      tick();
      check_eq("rise state", {31'b0, state[5]}, 32'h1);
      check_eq("rise irq pre", {31'b0, irq}, 32'h0);
      tick();
      check_eq("rise irq", {31'b0, irq}, 32'h1);
      clr = 32'h20; tick(); clr = '0;
      check_eq("clear state", {31'b0, state[5]}, 32'h0);
      tick();
      check_eq("clear irq", {31'b0, irq}, 32'h0);
      gpio_in[5] = 1'b0;
      repeat (5) tick();
      tst = 32'h20; tick(); tst = '0;
      check_eq("test sets 5", {31'b0, state[5]}, 32'h1);
      gpio_in[5] = 1'b1;
      repeat (3) tick();
      clr = 32'h20; tick(); clr = '0;
      check_eq("set beats clear", {31'b0, state[5]}, 32'h1);
      clr = 32'h20; tick(); clr = '0;
      check_eq("clear after rise", {31'b0, state[5]}, 32'h0);
      rise_en = '0; ien = '0;

      // Level-low on pin 7 persists through clears
      low_en = 32'h80;
      tick();
      check_eq("low sets", {31'b0, state[7]}, 32'h1);
      clr = 32'h80; tick(); clr = '0;
      check_eq("low reasserts", {31'b0, state[7]}, 32'h1);
      low_en = '0;
      clr = 32'h80; tick(); clr = '0;
      check_eq("low cleared", state, 32'h0);
      tst = 32'h80000000; tick(); tst = '0;
      check_eq("test pin 31", state, 32'h80000000);

      // Reset mid-filter / mid-interrupt
      ien = 32'h80000000; fen = '1; thresh = 4'd15; gpio_in = 32'h0F0F0F0F;
      repeat (4) tick();
      check_eq("pre-reset irq", {31'b0, irq}, 32'h1);
      rst = 1'b1;
      tick();
      check_zero("midreset");
      rst = 1'b0; gpio_in = '0;
      rise_en = '1; fall_en = '1; ien = '1;
      repeat (25) tick();
      check_eq("post-reset state", state, 32'h0);
      check_eq("post-reset irq", {31'b0, irq}, 32'h0);

      // Randomised segments against the model
      for (int seg = 0; seg < 6; seg++) begin
         clear_inputs();
         fen     = $urandom;
         thresh  = CW'($urandom_range(0, 5));
         rise_en = $urandom & $urandom;
         fall_en = $urandom & $urandom;
         high_en = $urandom & $urandom & $urandom;
         low_en  = $urandom & $urandom & $urandom;
         ien     = $urandom;
         od      = $urandom;
         rst = 1'b1;
         tick(); tick();
         rst = 1'b0;
         compare_all();
         for (int c = 0; c < 250; c++) begin
            gpio_in  = gpio_in ^ ($urandom & $urandom & $urandom & $urandom);
            clr      = $urandom & $urandom;
            tst      = ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : '0;
            out_we   = ($urandom_range(0, 3) == 0);
            out_mask = $urandom; out_data = $urandom;
            oe_we    = ($urandom_range(0, 3) == 0);
            oe_mask  = $urandom; oe_data = $urandom;
            rst      = ($urandom_range(0, 99) == 0);
            tick();
            compare_all();
         end
         rst = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
